// File: rtl/cas_player.sv
// Cassette tape player: stores a downloaded cassette image in an internal RAM and
// replays it as a Kansas-City style FSK square wave (1200 Hz = 0, 2400 Hz = 1), LSB first.
module cas_player #(
    parameter int ADDR_W    = 15,
    parameter int ZERO_HALF = 23863,
    parameter int ONE_HALF  = 11932
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [15:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              motor,
    input  logic              rewind,
    output logic              cas_bit,
    output logic              busy,
    output logic              eof,
    output logic [ADDR_W-1:0] byte_ptr
);

    localparam int MAX_HALF = (ZERO_HALF > ONE_HALF) ? ZERO_HALF : ONE_HALF;
    localparam int CNT_W    = $clog2(MAX_HALF + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        HIGH,
        LOW,
        DONE
    } state_t;

    state_t             state;
    logic [7:0]         ram [2**ADDR_W];
    logic [7:0]         ram_q;
    logic [7:0]         shreg;
    logic [2:0]         bit_cnt;
    logic [CNT_W-1:0]   half_cnt;
    logic [ADDR_W:0]    len;
    logic               dl_prev;

    logic               wr_ok;
    logic [ADDR_W:0]    wr_len;
    logic [ADDR_W:0]    len_base;
    logic [ADDR_W:0]    next_ptr;

    function automatic logic [CNT_W-1:0] half_of(input logic b);
        return b ? CNT_W'(ONE_HALF) : CNT_W'(ZERO_HALF);
    endfunction

    assign wr_ok    = ioctl_download && ioctl_wr && ((ioctl_addr >> ADDR_W) == 16'd0);
    assign wr_len   = {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);
    assign len_base = dl_prev ? len : '0;
    assign next_ptr = {1'b0, byte_ptr} + (ADDR_W+1)'(1);

    // Image RAM has no reset so a tape survives a machine reset; read port follows byte_ptr.
    always_ff @(posedge clk) begin
        if (wr_ok)
            ram[ioctl_addr[ADDR_W-1:0]] <= ioctl_data;
        ram_q <= ram[byte_ptr];
    end

    // Outputs are registered from the state of the previous cycle, so the wave lags the FSM by one clock.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cas_bit  <= 1'b0;
            busy     <= 1'b0;
            eof      <= 1'b0;
            byte_ptr <= '0;
            len      <= '0;
            bit_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= '0;
            dl_prev  <= 1'b0;
        end else begin
            dl_prev <= ioctl_download;
            if (ioctl_download) begin
                len      <= (wr_ok && (wr_len > len_base)) ? wr_len : len_base;
                state    <= IDLE;
                byte_ptr <= '0;
                eof      <= 1'b0;
                cas_bit  <= 1'b0;
                busy     <= 1'b0;
            end else if (rewind) begin
                state    <= IDLE;
                byte_ptr <= '0;
                eof      <= 1'b0;
                cas_bit  <= 1'b0;
                busy     <= 1'b0;
            end else begin
                cas_bit <= motor && (state == HIGH);
                busy    <= (state == FETCH) || (state == LOAD) || (state == HIGH) || (state == LOW);
                eof     <= (state == DONE);
                case (state)
                    IDLE: begin
                        if (motor)
                            state <= (len != '0) ? FETCH : DONE;
                    end
                    FETCH: begin
                        if (motor)
                            state <= LOAD;
                    end
                    LOAD: begin
                        if (motor) begin
                            shreg    <= ram_q;
                            bit_cnt  <= '0;
                            half_cnt <= half_of(ram_q[0]);
                            state    <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (motor) begin
                            if (half_cnt <= CNT_W'(1)) begin
                                half_cnt <= half_of(shreg[0]);
                                state    <= LOW;
                            end else begin
                                half_cnt <= half_cnt - CNT_W'(1);
                            end
                        end
                    end
                    LOW: begin
                        if (motor) begin
                            if (half_cnt > CNT_W'(1)) begin
                                half_cnt <= half_cnt - CNT_W'(1);
                            end else if (bit_cnt != 3'd7) begin
                                shreg    <= {1'b0, shreg[7:1]};
                                bit_cnt  <= bit_cnt + 3'd1;
                                half_cnt <= half_of(shreg[1]);
                                state    <= HIGH;
                            end else begin
                                half_cnt <= '0;
                                // A completely full buffer would push byte_ptr past its width; hold it instead.
                                if (!next_ptr[ADDR_W])
                                    byte_ptr <= next_ptr[ADDR_W-1:0];
                                state <= (next_ptr == len) ? DONE : FETCH;
                            end
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cas_player.sv
// Scoreboarded bench for cas_player: random tapes are turned into an ideal FSK bit stream
// by a byte-level model, and a monitor compares every motor-on clock against it.
module tb_cas_player;

    localparam int ADDR_W    = 8;
    localparam int ZERO_HALF = 8;
    localparam int ONE_HALF  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              ioctl_download = 1'b0;
    logic              ioctl_wr = 1'b0;
    logic [15:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_data = '0;
    logic              motor = 1'b0;
    logic              rewind = 1'b0;
    logic              cas_bit;
    logic              busy;
    logic              eof;
    logic [ADDR_W-1:0] byte_ptr;

    int   vectors = 0;
    int   miscompares = 0;
    logic expq [$];
    logic [7:0] mem_model [2**ADDR_W];
    int   len_model = 0;

    cas_player #(
        .ADDR_W   (ADDR_W),
        .ZERO_HALF(ZERO_HALF),
        .ONE_HALF (ONE_HALF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_data    (ioctl_data),
        .motor         (motor),
        .rewind        (rewind),
        .cas_bit       (cas_bit),
        .busy          (busy),
        .eof           (eof),
        .byte_ptr      (byte_ptr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each clock the motor was on consumes one ideal sample; motor-off clocks must be silent.
    initial begin
        logic m, dl, rw, rs, e;
        forever begin
            @(posedge clk);
            m  = motor;
            dl = ioctl_download;
            rw = rewind;
            rs = reset;
            #1;
            if (expq.size() > 0 && rs && !dl && !rw) begin
                if (m) begin
                    e = expq.pop_front();
                    checkOutput("cas_wave", cas_bit, e);
                end else begin
                    checkOutput("cas_frozen", cas_bit, 1'b0);
                end
            end
        end
    end

    task automatic startDownload();
        @(negedge clk);
        motor          = 1'b0;
        ioctl_download = 1'b1;
        len_model      = 0;
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        ioctl_wr   = 1'b1;
        ioctl_addr = addr;
        ioctl_data = data;
        if (addr < 16'(2**ADDR_W)) begin
            mem_model[addr] = data;
            if (int'(addr) + 1 > len_model)
                len_model = int'(addr) + 1;
        end
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic endDownload();
        @(negedge clk);
        ioctl_download = 1'b0;
        @(negedge clk);
    endtask

    task automatic downloadRandom(input int n, input bit even_first);
        logic [7:0] d;
        startDownload();
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            if (i == 0 && even_first)
                d[0] = 1'b0;
            applyStimulus(16'(i), d);
        end
        applyStimulus(16'h0100 + 16'($urandom_range(0, 255)), 8'($urandom));
        endDownload();
    endtask

    // Ideal stream from the motor edge: one idle sample, then per byte a 2-sample gap and 8 FSK cycles.
    task automatic buildExpected();
        int h;
        expq.delete();
        expq.push_back(1'b0);
        for (int p = 0; p < len_model; p++) begin
            expq.push_back(1'b0);
            expq.push_back(1'b0);
            for (int b = 0; b < 8; b++) begin
                h = mem_model[p][b] ? ONE_HALF : ZERO_HALF;
                for (int j = 0; j < h; j++) expq.push_back(1'b1);
                for (int j = 0; j < h; j++) expq.push_back(1'b0);
            end
        end
    endtask

    // abort_kind 0: plays to the end; 1: new download at cycle abort_at; 2: reset at first LOW after abort_at.
    task automatic playBack(input int drop_at, input bit rand_drops, input int abort_kind, input int abort_at);
        int   k = -1;
        int   hold = 0;
        bit   done = 1'b0;
        logic prev_cas = 1'b0;
        @(negedge clk);
        motor = 1'b1;
        while (!done) begin
            @(negedge clk);
            k++;
            if (k == 1)
                checkOutput("busy_after_motor", busy, 1'b1);
            if (abort_kind == 1 && k == abort_at) begin
                expq.delete();
                motor          = 1'b0;
                ioctl_download = 1'b1;
                len_model      = 0;
                done           = 1'b1;
            end else if (abort_kind == 2 && k > abort_at && prev_cas && !cas_bit) begin
                expq.delete();
                motor = 1'b0;
                reset = 1'b0;
                done  = 1'b1;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0)
                    motor = 1'b1;
            end else if (k == drop_at) begin
                motor = 1'b0;
                hold  = 20;
            end else if (rand_drops && expq.size() > 4 && $urandom_range(0, 39) == 0) begin
                motor = 1'b0;
                hold  = $urandom_range(1, 20);
            end else if (expq.size() == 0) begin
                done = 1'b1;
            end
            prev_cas = cas_bit;
            if (!done && k > 6000) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL play_timeout: %0d samples still pending after %0d cycles", expq.size(), k);
                expq.delete();
                done = 1'b1;
            end
        end
    endtask

    task automatic checkEnd(input string tag);
        repeat (2) @(negedge clk);
        checkOutput({tag, "_eof"}, eof, 1'b1);
        checkOutput({tag, "_byte_ptr"}, 32'(byte_ptr), 32'(len_model));
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_cas"}, cas_bit, 1'b0);
    endtask

    task automatic doRewind();
        @(negedge clk);
        motor  = 1'b0;
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        checkOutput("rewind_eof", eof, 1'b0);
        checkOutput("rewind_byte_ptr", 32'(byte_ptr), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_cas", cas_bit, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_eof", eof, 1'b0);
        checkOutput("reset_byte_ptr", 32'(byte_ptr), 32'd0);
        reset = 1'b1;

        // Empty tape: motor goes straight to end of file.
        @(negedge clk);
        motor = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("empty_eof", eof, 1'b1);
        checkOutput("empty_cas", cas_bit, 1'b0);
        checkOutput("empty_busy", busy, 1'b0);
        doRewind();

        // Known two-byte tape 0x01, 0x00 plus a dropped out-of-range write.
        startDownload();
        applyStimulus(16'd0, 8'h01);
        applyStimulus(16'd1, 8'h00);
        applyStimulus(16'h0100, 8'hFF);
        endDownload();
        buildExpected();
        playBack(-1, 1'b0, 0, 0);
        checkEnd("known");

        doRewind();
        buildExpected();
        playBack(-1, 1'b0, 0, 0);
        checkEnd("replay");

        // Motor pause three cycles into an 8-cycle HIGH, plus random pauses.
        downloadRandom(3, 1'b1);
        buildExpected();
        playBack(5, 1'b1, 0, 0);
        checkEnd("pause");

        for (int r = 0; r < 3; r++) begin
            downloadRandom($urandom_range(1, 4), 1'b0);
            buildExpected();
            playBack(-1, 1'b1, 0, 0);
            checkEnd("random");
        end

        // New download in the middle of a byte; only the new data may be played.
        downloadRandom(4, 1'b0);
        buildExpected();
        playBack(-1, 1'b0, 1, $urandom_range(20, 60));
        @(negedge clk);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_cas", cas_bit, 1'b0);
        checkOutput("abort_byte_ptr", 32'(byte_ptr), 32'd0);
        checkOutput("abort_eof", eof, 1'b0);
        applyStimulus(16'd0, 8'($urandom));
        applyStimulus(16'd1, 8'($urandom));
        endDownload();
        buildExpected();
        playBack(-1, 1'b1, 0, 0);
        checkEnd("newdata");

        // Reset while the wave is low clears everything, including the tape length.
        doRewind();
        buildExpected();
        playBack(-1, 1'b0, 2, 30);
        @(negedge clk);
        checkOutput("rst_low_cas", cas_bit, 1'b0);
        checkOutput("rst_low_busy", busy, 1'b0);
        checkOutput("rst_low_eof", eof, 1'b0);
        checkOutput("rst_low_byte_ptr", 32'(byte_ptr), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        motor = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_eof", eof, 1'b1);
        checkOutput("post_rst_busy", busy, 1'b0);
        motor = 1'b0;

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cas_player.md
CAS_PLAYER -- requirements
Module: cas_player

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15: cassette buffer address width (2^ADDR_W bytes).
REQ-002 The block SHALL have parameter ZERO_HALF, default 23863: clk cycles per half-period of a 0 bit (1200 Hz at 57.272 MHz).
REQ-003 The block SHALL have parameter ONE_HALF, default 11932: clk cycles per half-period of a 1 bit (2400 Hz).
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, 57.272 MHz.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port ioctl_download, input, 1 bit: cassette image download in progress.
REQ-007 The block SHALL have port ioctl_wr, input, 1 bit: write strobe for the download byte.
REQ-008 The block SHALL have port ioctl_addr, input, 16 bits: download byte address.
REQ-009 The block SHALL have port ioctl_data, input, 8 bits: download byte.
REQ-010 The block SHALL have port motor, input, 1 bit: cassette motor relay, from the PIA1 CA2 output.
REQ-011 The block SHALL have port rewind, input, 1 bit: single-cycle pulse that rewinds playback to byte 0.
REQ-012 The block SHALL have port cas_bit, output, 1 bit: FSK square wave to the PIA1 port A bit 0 (casdin).
REQ-013 The block SHALL have port busy, output, 1 bit: high in FETCH, LOAD, HIGH and LOW.
REQ-014 The block SHALL have port eof, output, 1 bit: all loaded bytes have been played.
REQ-015 The block SHALL have port byte_ptr, output, ADDR_W bits: index of the current byte.

Function
REQ-016 The block SHALL hold an internal single-clock byte RAM of 2^ADDR_W entries with one-cycle read latency.
REQ-017 While ioctl_download=1 and ioctl_wr=1, the block SHALL write ioctl_data to RAM[ioctl_addr[ADDR_W-1:0]]; writes with ioctl_addr >= 2^ADDR_W SHALL be dropped.
REQ-018 During a download, the block SHALL track len as the maximum accepted address plus 1; len SHALL be cleared at the download rising edge.
REQ-019 While ioctl_download=1, the block SHALL force state IDLE, byte_ptr=0, eof=0 and cas_bit=0, aborting any playback in progress.
REQ-020 The block SHALL implement the states IDLE, FETCH, LOAD, HIGH, LOW and DONE.
REQ-021 IDLE: if motor=1 and len>0, the next state SHALL be FETCH; if motor=1 and len=0, the next state SHALL be DONE.
REQ-022 FETCH: the block SHALL issue the RAM read at byte_ptr, and the next state SHALL be LOAD.
REQ-023 LOAD: the block SHALL capture the RAM data into the shift register, set bit_cnt=0, load the half counter from shreg[0], and the next state SHALL be HIGH.
REQ-024 Bits SHALL be sent LSB first; the half counter SHALL use ZERO_HALF for a 0 bit and ONE_HALF for a 1 bit.
REQ-025 HIGH: cas_bit SHALL be 1 for exactly the half count in cycles, then the block SHALL go to LOW and reload the same count.
REQ-026 LOW: cas_bit SHALL be 0 for exactly the half count in cycles; at expiry, if bit_cnt<7 the block SHALL shift, increment bit_cnt, reload the count and go to HIGH.
REQ-027 At LOW expiry with bit_cnt=7, the block SHALL increment byte_ptr; if the new byte_ptr equals len the next state SHALL be DONE, otherwise FETCH.
REQ-028 The two-cycle FETCH/LOAD gap between bytes SHALL output cas_bit=0.
REQ-029 Latency: if motor is sampled 1 in IDLE at edge N, cas_bit SHALL be 1 from edge N+3.
REQ-030 When motor=0 in any of FETCH, LOAD, HIGH or LOW, the block SHALL freeze the state, counters and shift register and force cas_bit=0; when motor=1 again, the block SHALL resume with the remaining count intact.
REQ-031 DONE: eof SHALL be 1 and cas_bit SHALL be 0; the block SHALL leave DONE only on rewind or a download.
REQ-032 rewind SHALL set byte_ptr=0, eof=0 and state=IDLE from any state; if rewind and ioctl_download are active together, the download behaviour SHALL take precedence (same result).
REQ-033 byte_ptr SHALL never exceed len and SHALL NOT wrap.

Reset
REQ-034 When reset=0 at a clk edge, the block SHALL set state=IDLE, cas_bit=0, busy=0, eof=0, byte_ptr=0, len=0, bit_cnt=0 and counters=0; RAM contents SHALL be retained.
REQ-035 Reset SHALL override download, rewind and motor.

Verification (bench parameters: ZERO_HALF=8, ONE_HALF=4, ADDR_W=8)
REQ-036 The bench SHALL download bytes 0x01, 0x00 at addresses 0–1 and then raise motor; the required response is: 8 bits of byte 0 where bit0 is high 4 / low 4 and bits 1–7 are high 8 / low 8 each, then byte 1 is all 8/8, then eof=1 and byte_ptr=2.
REQ-037 The bench SHALL raise motor at edge N with len>0; the required response is cas_bit=1 at N+3 and busy=1 at N+1.
REQ-038 The bench SHALL drop motor at 3 cycles into an 8-cycle HIGH for 20 cycles and then restore it; the required response is cas_bit=0 for those 20 cycles, then HIGH continues for exactly 5 more cycles.
REQ-039 The bench SHALL start a new download mid-byte; the required response is busy=0, cas_bit=0, byte_ptr=0 and eof=0 on the next cycle, with len reflecting only the new data.
REQ-040 The bench SHALL apply rewind in DONE and then raise motor; the required response is eof=0 and playback restarting at byte 0 with identical waveform.
REQ-041 The bench SHALL raise motor with len=0 (no download); the required response is DONE with eof=1, cas_bit=0 and busy=0; it SHALL also assert reset during LOW and check that all outputs are 0 on the next cycle.
